// File: rtl/vram_pkg.sv
// Shared definitions for the video SRAM controller: FSM state encoding and default timing.
package vram_pkg;

    localparam int RD_WAIT       = 2;
    localparam int WR_WAIT       = 2;
    localparam int MAX_VID_BURST = 4;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_RD       = 3'd1,
        ST_WR_SETUP = 3'd2,
        ST_WR_PULSE = 3'd3,
        ST_WR_HOLD  = 3'd4
    } state_t;

endpackage

// File: rtl/vram_arbiter.sv
// Video-over-CPU priority select with a starvation counter that forces the CPU in after a burst of video grants.
module vram_arbiter #(
    parameter int MAX_VID_BURST = 4
) (
    input  logic clk,
    input  logic reset_n,
    input  logic en,
    input  logic vid_req,
    input  logic cpu_req,
    output logic grant_vid,
    output logic grant_cpu
);

    localparam int SC_W = $clog2(MAX_VID_BURST + 1);

    logic [SC_W-1:0] starv_cnt;
    logic            starved;

    assign starved   = (starv_cnt == SC_W'(MAX_VID_BURST));
    assign grant_vid = en & vid_req & ~(cpu_req & starved);
    assign grant_cpu = en & cpu_req & (~vid_req | starved);

    // Counts only video grants taken while the CPU is waiting; saturates via the starved override.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            starv_cnt <= '0;
        end else if (!cpu_req || grant_cpu) begin
            starv_cnt <= '0;
        end else if (grant_vid) begin
            starv_cnt <= starv_cnt + SC_W'(1);
        end
    end

endmodule

// File: rtl/vram_sram_ctrl.sv
// Sequencer for the external 512Kx8 async video SRAM; all pin and ack outputs are registered.
//
// state       | meaning
// ST_IDLE     | strobes high, bus released, requests sampled
// ST_RD       | CE#/OE# low for RD_WAIT cycles, data sampled on exit
// ST_WR_SETUP | CE# low, data driven, WE# still high
// ST_WR_PULSE | WE# low for WR_WAIT cycles
// ST_WR_HOLD  | WE# high with address/data held; SRAM commits here
module vram_sram_ctrl
    import vram_pkg::*;
#(
    parameter int ADDR_W        = 19,
    parameter int DATA_W        = 8,
    parameter int RD_WAIT       = vram_pkg::RD_WAIT,
    parameter int WR_WAIT       = vram_pkg::WR_WAIT,
    parameter int MAX_VID_BURST = vram_pkg::MAX_VID_BURST
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              vid_req,
    input  logic [ADDR_W-1:0] vid_addr,
    output logic              vid_ack,
    output logic [DATA_W-1:0] vid_rdata,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ack,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic [ADDR_W-1:0] sram_a,
    inout  wire  [DATA_W-1:0] sram_d,
    output logic              sram_ce_l,
    output logic              sram_oe_l,
    output logic              sram_we_l
);

    localparam int MAX_WAIT = (RD_WAIT > WR_WAIT) ? RD_WAIT : WR_WAIT;
    localparam int CNT_W    = $clog2(MAX_WAIT + 1);

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic [ADDR_W-1:0] a_nxt;
    logic [DATA_W-1:0] wdata_q, wdata_nxt;
    logic [DATA_W-1:0] vid_rdata_nxt, cpu_rdata_nxt;
    logic              is_vid, is_vid_nxt;
    logic              drive_en, drive_nxt;
    logic              ce_nxt, oe_nxt, we_nxt;
    logic              vid_ack_nxt, cpu_ack_nxt;
    logic              grant_vid, grant_cpu;

    vram_arbiter #(
        .MAX_VID_BURST(MAX_VID_BURST)
    ) u_arb (
        .clk      (clk),
        .reset_n  (reset_n),
        .en       (state == ST_IDLE),
        .vid_req  (vid_req),
        .cpu_req  (cpu_req),
        .grant_vid(grant_vid),
        .grant_cpu(grant_cpu)
    );

    assign sram_d = drive_en ? wdata_q : {DATA_W{1'bz}};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            sram_a    <= '0;
            wdata_q   <= '0;
            is_vid    <= 1'b0;
            drive_en  <= 1'b0;
            sram_ce_l <= 1'b1;
            sram_oe_l <= 1'b1;
            sram_we_l <= 1'b1;
            vid_ack   <= 1'b0;
            cpu_ack   <= 1'b0;
            vid_rdata <= '0;
            cpu_rdata <= '0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            sram_a    <= a_nxt;
            wdata_q   <= wdata_nxt;
            is_vid    <= is_vid_nxt;
            drive_en  <= drive_nxt;
            sram_ce_l <= ce_nxt;
            sram_oe_l <= oe_nxt;
            sram_we_l <= we_nxt;
            vid_ack   <= vid_ack_nxt;
            cpu_ack   <= cpu_ack_nxt;
            vid_rdata <= vid_rdata_nxt;
            cpu_rdata <= cpu_rdata_nxt;
        end
    end

    // Next values of every registered output; strobes default high so IDLE always releases the bus.
    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        a_nxt         = sram_a;
        wdata_nxt     = wdata_q;
        is_vid_nxt    = is_vid;
        drive_nxt     = 1'b0;
        ce_nxt        = 1'b1;
        oe_nxt        = 1'b1;
        we_nxt        = 1'b1;
        vid_ack_nxt   = 1'b0;
        cpu_ack_nxt   = 1'b0;
        vid_rdata_nxt = vid_rdata;
        cpu_rdata_nxt = cpu_rdata;

        case (state)
            ST_IDLE: begin
                if (grant_vid) begin
                    state_nxt  = ST_RD;
                    a_nxt      = vid_addr;
                    is_vid_nxt = 1'b1;
                    cnt_nxt    = CNT_W'(RD_WAIT - 1);
                    ce_nxt     = 1'b0;
                    oe_nxt     = 1'b0;
                end else if (grant_cpu) begin
                    a_nxt      = cpu_addr;
                    is_vid_nxt = 1'b0;
                    ce_nxt     = 1'b0;
                    if (cpu_we) begin
                        state_nxt = ST_WR_SETUP;
                        wdata_nxt = cpu_wdata;
                        drive_nxt = 1'b1;
                    end else begin
                        state_nxt = ST_RD;
                        cnt_nxt   = CNT_W'(RD_WAIT - 1);
                        oe_nxt    = 1'b0;
                    end
                end
            end
            ST_RD: begin
                if (cnt == '0) begin
                    state_nxt = ST_IDLE;
                    if (is_vid) begin
                        vid_rdata_nxt = sram_d;
                        vid_ack_nxt   = 1'b1;
                    end else begin
                        cpu_rdata_nxt = sram_d;
                        cpu_ack_nxt   = 1'b1;
                    end
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                    ce_nxt  = 1'b0;
                    oe_nxt  = 1'b0;
                end
            end
            ST_WR_SETUP: begin
                state_nxt = ST_WR_PULSE;
                cnt_nxt   = CNT_W'(WR_WAIT - 1);
                ce_nxt    = 1'b0;
                we_nxt    = 1'b0;
                drive_nxt = 1'b1;
            end
            ST_WR_PULSE: begin
                ce_nxt    = 1'b0;
                drive_nxt = 1'b1;
                if (cnt == '0) begin
                    state_nxt = ST_WR_HOLD;
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                    we_nxt  = 1'b0;
                end
            end
            ST_WR_HOLD: begin
                state_nxt   = ST_IDLE;
                cpu_ack_nxt = 1'b1;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_vram_sram_ctrl.sv
// Directed bench for vram_sram_ctrl with a behavioural async SRAM preloaded with byte[i] = i & 0xFF.
`timescale 1ns/1ps
module tb_vram_sram_ctrl;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        vid_req, cpu_req, cpu_we;
    logic [18:0] vid_addr, cpu_addr;
    logic [7:0]  cpu_wdata;
    logic        vid_ack, cpu_ack;
    logic [7:0]  vid_rdata, cpu_rdata;
    logic [18:0] sram_a;
    wire  [7:0]  sram_d;
    logic        sram_ce_l, sram_oe_l, sram_we_l;

    int tests = 0;
    int fails = 0;

    logic [7:0] mem [0:524287];

    always #10 clk = ~clk;

    vram_sram_ctrl dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .vid_req  (vid_req),
        .vid_addr (vid_addr),
        .vid_ack  (vid_ack),
        .vid_rdata(vid_rdata),
        .cpu_req  (cpu_req),
        .cpu_we   (cpu_we),
        .cpu_addr (cpu_addr),
        .cpu_wdata(cpu_wdata),
        .cpu_ack  (cpu_ack),
        .cpu_rdata(cpu_rdata),
        .sram_a   (sram_a),
        .sram_d   (sram_d),
        .sram_ce_l(sram_ce_l),
        .sram_oe_l(sram_oe_l),
        .sram_we_l(sram_we_l)
    );

    assign sram_d = (!sram_ce_l && !sram_oe_l && sram_we_l) ? mem[sram_a] : 8'hzz;

    always @(posedge sram_we_l) begin
        if (sram_ce_l === 1'b0) mem[sram_a] <= sram_d;
    end

    // Runs one CPU access starting just after an edge; the first edge it waits on is the grant edge.
    task automatic cpu_access(input logic we, input logic [18:0] addr, input logic [7:0] wd,
                              input bit drop, output int lat, output int oe_low,
                              output int we_low, output bit d_bad, output bit got);
        lat = -1; oe_low = 0; we_low = 0; d_bad = 1'b0; got = 1'b0;
        cpu_we = we; cpu_addr = addr; cpu_wdata = wd; cpu_req = 1'b1;
        for (int i = 1; i <= 20 && !got; i++) begin
            @(posedge clk); #1;
            if (!sram_oe_l) oe_low++;
            if (!sram_we_l) begin
                we_low++;
                if (sram_d !== wd || sram_a !== addr) d_bad = 1'b1;
            end
            if (cpu_ack) begin
                got = 1'b1;
                lat = i - 1;
                if (drop) cpu_req = 1'b0;
            end
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        vid_req = 0; cpu_req = 0; cpu_we = 0;
        vid_addr = '0; cpu_addr = '0; cpu_wdata = '0;
        repeat (3) @(posedge clk);
        @(negedge clk) reset_n = 1'b1;
        @(posedge clk); #1;
        tests++;
        if ({sram_ce_l, sram_oe_l, sram_we_l} !== 3'b111) begin
            fails++; $display("FAIL reset_strobes got %b want 111", {sram_ce_l, sram_oe_l, sram_we_l});
        end
        tests++;
        if (dut.drive_en !== 1'b0) begin
            fails++; $display("FAIL reset_bus got drive_en=%b want 0", dut.drive_en);
        end
        tests++;
        if ({vid_ack, cpu_ack} !== 2'b00 || vid_rdata !== 8'h00 || cpu_rdata !== 8'h00) begin
            fails++; $display("FAIL reset_outputs got acks=%b vrd=%h crd=%h want 00/00/00",
                              {vid_ack, cpu_ack}, vid_rdata, cpu_rdata);
        end
        tests++;
        if (sram_a !== 19'h0) begin
            fails++; $display("FAIL reset_addr got %h want 0", sram_a);
        end
    endtask

    task automatic test_cpu_read();
        int lat, oe_low, we_low; bit d_bad, got;
        cpu_access(1'b0, 19'h00005, 8'h00, 1'b1, lat, oe_low, we_low, d_bad, got);
        tests++;
        if (!got || lat != 2) begin
            fails++; $display("FAIL rd_latency got %0d want 2", lat);
        end
        tests++;
        if (cpu_rdata !== 8'h05) begin
            fails++; $display("FAIL rd_data got %h want 05", cpu_rdata);
        end
        tests++;
        if (oe_low != 2 || we_low != 0) begin
            fails++; $display("FAIL rd_strobes got oe_low=%0d we_low=%0d want 2/0", oe_low, we_low);
        end
    endtask

    task automatic test_write_read();
        int lat, oe_low, we_low; bit d_bad, got;
        cpu_access(1'b1, 19'h00010, 8'hA5, 1'b0, lat, oe_low, we_low, d_bad, got);
        tests++;
        if (!got || lat != 4) begin
            fails++; $display("FAIL wr_latency got %0d want 4", lat);
        end
        tests++;
        if (oe_low != 0 || we_low != 2 || d_bad) begin
            fails++; $display("FAIL wr_strobes got oe_low=%0d we_low=%0d d_bad=%0d want 0/2/0",
                              oe_low, we_low, d_bad);
        end
        tests++;
        if (sram_ce_l !== 1'b1 || dut.drive_en !== 1'b0) begin
            fails++; $display("FAIL wr_ack_idle got ce_l=%b drive=%b want 1/0", sram_ce_l, dut.drive_en);
        end
        cpu_access(1'b0, 19'h00010, 8'h00, 1'b1, lat, oe_low, we_low, d_bad, got);
        tests++;
        if (!got || lat != 2) begin
            fails++; $display("FAIL wr_rd_gap got latency %0d want 2", lat);
        end
        tests++;
        if (cpu_rdata !== 8'hA5) begin
            fails++; $display("FAIL wr_rd_data got %h want a5", cpu_rdata);
        end
    endtask

    task automatic test_priority();
        int vid_at = -1, cpu_at = -1;
        vid_addr = 19'h00020; cpu_addr = 19'h00030; cpu_we = 1'b0;
        vid_req = 1'b1; cpu_req = 1'b1;
        for (int i = 1; i <= 30 && cpu_at < 0; i++) begin
            @(posedge clk); #1;
            if (vid_ack) begin vid_at = i; vid_req = 1'b0; end
            if (cpu_ack) begin cpu_at = i; cpu_req = 1'b0; end
        end
        tests++;
        if (vid_at != 3 || vid_rdata !== 8'h20) begin
            fails++; $display("FAIL prio_vid got cycle=%0d data=%h want 3/20", vid_at, vid_rdata);
        end
        tests++;
        if (cpu_at != 6 || cpu_rdata !== 8'h30) begin
            fails++; $display("FAIL prio_cpu got cycle=%0d data=%h want 6/30", cpu_at, cpu_rdata);
        end
    endtask

    task automatic test_starvation();
        int vid_cnt = 0, max_starv = 0;
        bit got = 1'b0;
        int starv_at_ack = -1;
        vid_addr = 19'h00023; cpu_addr = 19'h00007; cpu_we = 1'b0;
        vid_req = 1'b1; cpu_req = 1'b1;
        for (int i = 1; i <= 60 && !got; i++) begin
            @(posedge clk); #1;
            if (int'(dut.u_arb.starv_cnt) > max_starv) max_starv = int'(dut.u_arb.starv_cnt);
            if (vid_ack) vid_cnt++;
            if (cpu_ack) begin
                got = 1'b1;
                starv_at_ack = int'(dut.u_arb.starv_cnt);
                cpu_req = 1'b0; vid_req = 1'b0;
            end
        end
        tests++;
        if (!got || vid_cnt != 4) begin
            fails++; $display("FAIL starv_grants got %0d video grants (cpu_ack=%0d) want 4", vid_cnt, got);
        end
        tests++;
        if (max_starv != 4 || starv_at_ack != 0) begin
            fails++; $display("FAIL starv_cnt got max=%0d at_ack=%0d want 4/0", max_starv, starv_at_ack);
        end
        tests++;
        if (cpu_rdata !== 8'h07 || vid_rdata !== 8'h23) begin
            fails++; $display("FAIL starv_data got cpu=%h vid=%h want 07/23", cpu_rdata, vid_rdata);
        end
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid_write();
        bit in_pulse = 1'b0;
        int late_acks = 0;
        cpu_we = 1'b1; cpu_addr = 19'h00040; cpu_wdata = 8'h5A; cpu_req = 1'b1;
        for (int i = 1; i <= 10 && !in_pulse; i++) begin
            @(posedge clk); #1;
            if (sram_we_l === 1'b0) in_pulse = 1'b1;
        end
        tests++;
        if (!in_pulse) begin
            fails++; $display("FAIL rst_wr_pulse got no WE# pulse want pulse within 10 cycles");
        end
        #3 reset_n = 1'b0;
        #1;
        tests++;
        if (sram_we_l !== 1'b1 || sram_ce_l !== 1'b1 || dut.drive_en !== 1'b0) begin
            fails++; $display("FAIL rst_strobes got we_l=%b ce_l=%b drive=%b want 1/1/0",
                              sram_we_l, sram_ce_l, dut.drive_en);
        end
        cpu_req = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk) reset_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (cpu_ack) late_acks++;
        end
        tests++;
        if (late_acks != 0) begin
            fails++; $display("FAIL rst_no_ack got %0d acks want 0", late_acks);
        end
        tests++;
        if (mem[19'h00041] !== 8'h41) begin
            fails++; $display("FAIL rst_neighbour got %h want 41", mem[19'h00041]);
        end
        tests++;
        if (cpu_rdata !== 8'h00 || sram_a !== 19'h0) begin
            fails++; $display("FAIL rst_regs got rdata=%h a=%h want 00/0", cpu_rdata, sram_a);
        end
    endtask

    initial begin
        for (int i = 0; i < 524288; i++) mem[i] = i[7:0];
        test_reset();
        test_cpu_read();
        test_write_read();
        test_priority();
        test_starvation();
        test_reset_mid_write();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
